// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle between the pipeline and the branch predictor.
// The pipeline drives through the master modport; the predictor uses the slave modport.
interface branch_predictor_if #(
  parameter int DWIDTH = 32
);
  logic [DWIDTH-1:0] pc_if;
  logic              pred_taken_if;
  logic [DWIDTH-1:0] pred_target_if;
  logic              valid_ex;
  logic [DWIDTH-1:0] instruction_ex;
  logic [DWIDTH-1:0] pc_ex;
  logic              taken_ex;
  logic [DWIDTH-1:0] target_ex;
  logic              pred_taken_ex;
  logic [DWIDTH-1:0] pred_target_ex;
  logic              mispredict;
  logic [DWIDTH-1:0] redirect_pc;
  logic [31:0]       branch_cnt;
  logic [31:0]       mispredict_cnt;

  modport master (
    output pc_if, valid_ex, instruction_ex, pc_ex, taken_ex, target_ex,
           pred_taken_ex, pred_target_ex,
    input  pred_taken_if, pred_target_if, mispredict, redirect_pc,
           branch_cnt, mispredict_cnt
  );

  modport slave (
    input  pc_if, valid_ex, instruction_ex, pc_ex, taken_ex, target_ex,
           pred_taken_ex, pred_target_ex,
    output pred_taken_if, pred_target_if, mispredict, redirect_pc,
           branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational fetch lookup,
// EX-stage training, registered redirect on misprediction and performance counters.
module branch_predictor #(
  parameter int  DWIDTH  = 32,
  parameter int  ENTRIES = 16,
  localparam int IDXW    = $clog2(ENTRIES)
) (
  input logic               clk,
  input logic               rst_n,
  branch_predictor_if.slave bp
);
  localparam int TAGW = DWIDTH - IDXW - 2;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] CTR_RESET    = 2'b01;
  localparam logic [1:0] CTR_WEAK_T   = 2'b10;
  localparam logic [1:0] CTR_STRONG_T = 2'b11;

  localparam logic [DWIDTH-1:0] PC_STEP = DWIDTH'(32'd4);

  function automatic logic [1:0] f_ctr_up(input logic [1:0] c);
    logic [1:0] v;
    v = (c == 2'b11) ? 2'b11 : (c + 2'b01);
    return v;
  endfunction

  function automatic logic [1:0] f_ctr_down(input logic [1:0] c);
    logic [1:0] v;
    v = (c == 2'b00) ? 2'b00 : (c - 2'b01);
    return v;
  endfunction

  logic [ENTRIES-1:0]             r_valid;
  logic [ENTRIES-1:0][TAGW-1:0]   r_tag;
  logic [ENTRIES-1:0][DWIDTH-1:0] r_target;
  logic [ENTRIES-1:0][1:0]        r_ctr;

  logic              r_mispredict;
  logic [DWIDTH-1:0] r_redirect_pc;
  logic [31:0]       r_branch_cnt;
  logic [31:0]       r_mispredict_cnt;

  logic [IDXW-1:0]   w_if_idx;
  logic [TAGW-1:0]   w_if_tag;
  logic              w_if_hit;
  logic              w_pred_taken;

  logic [6:0]        w_opcode;
  logic              w_is_branch;
  logic              w_is_jump;
  logic              w_is_cfi;
  logic [IDXW-1:0]   w_ex_idx;
  logic [TAGW-1:0]   w_ex_tag;
  logic              w_ex_hit;

  logic              w_ctr_wr;
  logic              w_alloc;
  logic [1:0]        w_new_ctr;
  logic              w_mis;
  logic [DWIDTH-1:0] w_correct_pc;
  logic              w_unused_bits;

  // Fetch lookup reads only registered state, so a same-cycle update is not seen.
  assign w_if_idx     = bp.pc_if[IDXW+1:2];
  assign w_if_tag     = bp.pc_if[DWIDTH-1:IDXW+2];
  assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_pred_taken = w_if_hit && r_ctr[w_if_idx][1];

  assign bp.pred_taken_if  = w_pred_taken;
  assign bp.pred_target_if = w_pred_taken ? r_target[w_if_idx] : {DWIDTH{1'b0}};

  assign w_opcode    = bp.instruction_ex[6:0];
  assign w_is_branch = (w_opcode == OP_BRANCH);
  assign w_is_jump   = (w_opcode == OP_JAL) || (w_opcode == OP_JALR);
  assign w_is_cfi    = w_is_branch || w_is_jump;
  assign w_ex_idx    = bp.pc_ex[IDXW+1:2];
  assign w_ex_tag    = bp.pc_ex[DWIDTH-1:IDXW+2];
  assign w_ex_hit    = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  assign w_unused_bits = ^{bp.instruction_ex[DWIDTH-1:7], bp.pc_if[1:0]};

  // Training decision: counter write and whether tag/target are (re)allocated.
  always_comb begin
    w_ctr_wr  = 1'b0;
    w_alloc   = 1'b0;
    w_new_ctr = r_ctr[w_ex_idx];
    if (bp.valid_ex && w_is_branch) begin
      if (bp.taken_ex) begin
        w_ctr_wr  = 1'b1;
        w_alloc   = 1'b1;
        w_new_ctr = w_ex_hit ? f_ctr_up(r_ctr[w_ex_idx]) : CTR_WEAK_T;
      end else if (w_ex_hit) begin
        w_ctr_wr  = 1'b1;
        w_new_ctr = f_ctr_down(r_ctr[w_ex_idx]);
      end else begin
        w_ctr_wr  = 1'b0;
      end
    end else if (bp.valid_ex && w_is_jump && bp.taken_ex) begin
      w_ctr_wr  = 1'b1;
      w_alloc   = 1'b1;
      w_new_ctr = CTR_STRONG_T;
    end else begin
      w_ctr_wr  = 1'b0;
      w_alloc   = 1'b0;
    end
  end

  // Misprediction detection and the architecturally correct next PC.
  always_comb begin
    w_mis        = 1'b0;
    w_correct_pc = bp.pc_ex + PC_STEP;
    if (bp.valid_ex) begin
      if (w_is_cfi) begin
        w_mis = (bp.taken_ex != bp.pred_taken_ex) ||
                (bp.taken_ex && bp.pred_taken_ex && (bp.target_ex != bp.pred_target_ex));
        if (bp.taken_ex) begin
          w_correct_pc = bp.target_ex;
        end else begin
          w_correct_pc = bp.pc_ex + PC_STEP;
        end
      end else begin
        w_mis = bp.pred_taken_ex;
      end
    end else begin
      w_mis = 1'b0;
    end
  end

  // BTB storage, written at the edge closing the EX cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= {ENTRIES{1'b0}};
      r_tag    <= {(ENTRIES*TAGW){1'b0}};
      r_target <= {(ENTRIES*DWIDTH){1'b0}};
      r_ctr    <= {ENTRIES{CTR_RESET}};
    end else begin
      if (w_ctr_wr) begin
        r_ctr[w_ex_idx] <= w_new_ctr;
      end
      if (w_alloc) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= bp.target_ex;
      end
    end
  end

  // Redirect pulse and performance counters; redirect_pc holds between events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mispredict     <= 1'b0;
      r_redirect_pc    <= {DWIDTH{1'b0}};
      r_branch_cnt     <= 32'd0;
      r_mispredict_cnt <= 32'd0;
    end else begin
      r_mispredict <= w_mis;
      if (w_mis) begin
        r_redirect_pc    <= w_correct_pc;
        r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
      end else begin
        r_redirect_pc    <= r_redirect_pc;
        r_mispredict_cnt <= r_mispredict_cnt;
      end
      if (bp.valid_ex && w_is_cfi) begin
        r_branch_cnt <= r_branch_cnt + 32'd1;
      end else begin
        r_branch_cnt <= r_branch_cnt;
      end
    end
  end

  assign bp.mispredict     = r_mispredict;
  assign bp.redirect_pc    = r_redirect_pc;
  assign bp.branch_cnt     = r_branch_cnt;
  assign bp.mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic compared every cycle against an array-based reference model.
module tb_branch_predictor;
  localparam int DW   = 32;
  localparam int ENT  = 16;
  localparam int IDXW = 4;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_predictor_if #(.DWIDTH(DW)) bp ();
  branch_predictor #(.DWIDTH(DW), .ENTRIES(ENT)) dut (.clk(clk), .rst_n(rst_n), .bp(bp));

  // Reference model state
  bit          m_valid  [ENT];
  logic [31:0] m_tag    [ENT];
  logic [31:0] m_target [ENT];
  int          m_ctr    [ENT];
  bit          exp_misp;
  logic [31:0] exp_redir;
  logic [31:0] exp_bcnt;
  logic [31:0] exp_mcnt;

  int n_pass  = 0;
  int n_total = 0;
  bit check_en = 1'b0;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc >> (IDXW + 2);
  endfunction

  function automatic bit mdl_taken(logic [31:0] pc);
    int i;
    i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] mdl_target(logic [31:0] pc);
    return mdl_taken(pc) ? m_target[idx_of(pc)] : 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 32'h0; m_target[i] = 32'h0; m_ctr[i] = 1;
    end
    exp_misp = 1'b0; exp_redir = 32'h0; exp_bcnt = 32'h0; exp_mcnt = 32'h0;
  endtask

  // Applies one EX-stage resolution to the model, following the predictor rules.
  task automatic model_update();
    logic [6:0] op;
    bit is_br, is_j, cfi, hit, mis, tk, ptk;
    int i;
    op    = bp.instruction_ex[6:0];
    is_br = (op == OP_BR);
    is_j  = (op == OP_JAL) || (op == OP_JALR);
    cfi   = is_br || is_j;
    tk    = bp.taken_ex;
    ptk   = bp.pred_taken_ex;
    if (!bp.valid_ex) begin
      exp_misp = 1'b0;
      return;
    end
    i   = idx_of(bp.pc_ex);
    hit = m_valid[i] && (m_tag[i] == tag_of(bp.pc_ex));
    if (cfi) mis = (tk != ptk) || (tk && ptk && (bp.target_ex != bp.pred_target_ex));
    else     mis = ptk;
    exp_misp = mis;
    if (mis) begin
      exp_redir = (cfi && tk) ? bp.target_ex : (bp.pc_ex + 32'd4);
      exp_mcnt  = exp_mcnt + 32'd1;
    end
    if (cfi) exp_bcnt = exp_bcnt + 32'd1;
    if (is_br && tk) begin
      m_ctr[i] = hit ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : 2;
      m_valid[i] = 1'b1; m_tag[i] = tag_of(bp.pc_ex); m_target[i] = bp.target_ex;
    end else if (is_br && hit) begin
      m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
    end else if (is_j && tk) begin
      m_ctr[i] = 3;
      m_valid[i] = 1'b1; m_tag[i] = tag_of(bp.pc_ex); m_target[i] = bp.target_ex;
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      check("pred_taken_if",  32'(bp.pred_taken_if), 32'(mdl_taken(bp.pc_if)));
      check("pred_target_if", bp.pred_target_if,     mdl_target(bp.pc_if));
      check("mispredict",     32'(bp.mispredict),    32'(exp_misp));
      check("redirect_pc",    bp.redirect_pc,        exp_redir);
      check("branch_cnt",     bp.branch_cnt,         exp_bcnt);
      check("mispredict_cnt", bp.mispredict_cnt,     exp_mcnt);
    end
  end

  task automatic drive_ex(bit v, logic [6:0] op, logic [31:0] pc, bit tk,
                          logic [31:0] tgt, bit ptk, logic [31:0] ptgt);
    logic [31:0] ins;
    ins = $urandom();
    ins[6:0] = op;
    bp.valid_ex = v; bp.instruction_ex = ins; bp.pc_ex = pc; bp.taken_ex = tk;
    bp.target_ex = tgt; bp.pred_taken_ex = ptk; bp.pred_target_ex = ptgt;
  endtask

  task automatic drive_idle();
    drive_ex(1'b0, OP_ADD, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic look(logic [31:0] pc);
    bp.pc_if = pc;
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    if ($urandom_range(0, 19) == 0) p = 32'hFFFF_FFFC;
    else p = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, ENT - 1)) << 2);
    return p;
  endfunction

  task automatic random_phase(int cycles);
    logic [31:0] pc, tgt, ptgt;
    logic [6:0]  op;
    bit v, tk, ptk;
    int r;
    for (int n = 0; n < cycles; n++) begin
      pc = rand_pc();
      r  = $urandom_range(0, 9);
      op = (r < 5) ? OP_BR : (r == 5) ? OP_JAL : (r == 6) ? OP_JALR : (r == 7) ? OP_LD : OP_ADD;
      tk = ((op == OP_JAL) || (op == OP_JALR)) ? 1'b1 : 1'($urandom_range(0, 1));
      tgt = ($urandom_range(0, 1) == 1) ? (32'($urandom_range(0, 7)) << 7) : ($urandom() & 32'hFFFF_FFFC);
      if ($urandom_range(0, 9) < 7) begin
        ptk = mdl_taken(pc); ptgt = mdl_target(pc);
      end else begin
        ptk = 1'($urandom_range(0, 1)); ptgt = 32'($urandom_range(0, 7)) << 7;
      end
      v = ($urandom_range(0, 9) != 0);
      drive_ex(v, op, pc, tk, tgt, ptk, ptgt);
      bp.pc_if = rand_pc();
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bp.pc_if = 32'h100;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_en = 1'b1;
    #1;
    check("rst pred_taken",  32'(bp.pred_taken_if), 32'h0);
    check("rst pred_target", bp.pred_target_if,     32'h0);
    check("rst mispredict",  32'(bp.mispredict),    32'h0);
    check("rst redirect",    bp.redirect_pc,        32'h0);
    check("rst bcnt",        bp.branch_cnt,         32'h0);
    check("rst mcnt",        bp.mispredict_cnt,     32'h0);

    // Train BEQ at 0x100 taken to 0x80, then not-taken twice
    drive_ex(1'b1, OP_BR, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0); step();
    drive_idle(); look(32'h100);
    check("beq1 mispredict", 32'(bp.mispredict),    32'h1);
    check("beq1 redirect",   bp.redirect_pc,        32'h80);
    check("beq1 pred_taken", 32'(bp.pred_taken_if), 32'h1);
    check("beq1 pred_tgt",   bp.pred_target_if,     32'h80);
    look(32'h140);
    check("alias 0x140",     32'(bp.pred_taken_if), 32'h0);
    drive_ex(1'b1, OP_BR, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80); step();
    drive_ex(1'b1, OP_BR, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80); step();
    drive_idle(); look(32'h100);
    check("beq3 mispredict", 32'(bp.mispredict),    32'h1);
    check("beq3 redirect",   bp.redirect_pc,        32'h104);
    check("beq3 pred_taken", 32'(bp.pred_taken_if), 32'h0);

    // Saturation of BNE at 0x200
    drive_ex(1'b1, OP_BR, 32'h200, 1'b1, 32'h180, 1'b0, 32'h0); step();
    for (int k = 0; k < 4; k++) begin
      drive_ex(1'b1, OP_BR, 32'h200, 1'b1, 32'h180, 1'b1, 32'h180); step();
    end
    drive_idle(); look(32'h200);
    check("bne sat mispredict", 32'(bp.mispredict),    32'h0);
    check("bne sat pred",       32'(bp.pred_taken_if), 32'h1);
    drive_ex(1'b1, OP_BR, 32'h200, 1'b0, 32'h180, 1'b1, 32'h180); step();
    drive_idle(); look(32'h200);
    check("bne nt pred",     32'(bp.pred_taken_if), 32'h1);
    check("bne nt tgt",      bp.pred_target_if,     32'h180);
    check("bne nt redirect", bp.redirect_pc,        32'h204);

    // JALR allocation and target retrain
    drive_ex(1'b1, OP_JALR, 32'h300, 1'b1, 32'h400, 1'b0, 32'h0); step();
    drive_idle(); look(32'h300);
    check("jalr alloc tgt", bp.pred_target_if, 32'h400);
    look(32'h200);
    check("alias 0x200", 32'(bp.pred_taken_if), 32'h0);
    look(32'h340);
    check("alias 0x340", 32'(bp.pred_taken_if), 32'h0);
    drive_ex(1'b1, OP_JALR, 32'h300, 1'b1, 32'h500, 1'b1, 32'h400); step();
    drive_idle(); look(32'h300);
    check("jalr2 mispredict", 32'(bp.mispredict), 32'h1);
    check("jalr2 redirect",   bp.redirect_pc,     32'h500);
    check("jalr2 new tgt",    bp.pred_target_if,  32'h500);

    // Non-cfi predicted taken
    drive_ex(1'b1, OP_ADD, 32'h40, 1'b0, 32'h0, 1'b1, 32'h500); step();
    drive_idle(); look(32'h300);
    check("add mispredict", 32'(bp.mispredict), 32'h1);
    check("add redirect",   bp.redirect_pc,     32'h44);
    check("add table kept", bp.pred_target_if,  32'h500);
    check("add bcnt",       bp.branch_cnt,      32'd11);
    check("add mcnt",       bp.mispredict_cnt,  32'd8);

    // PC wrap and bubble
    drive_ex(1'b1, OP_BR, 32'hFFFF_FFFC, 1'b0, 32'h10, 1'b1, 32'h10); step();
    drive_idle(); #1;
    check("wrap redirect", bp.redirect_pc, 32'h0);
    check("wrap bcnt",     bp.branch_cnt,  32'd12);
    drive_ex(1'b0, OP_BR, 32'h100, 1'b1, 32'h80, 1'b1, 32'h999); step();
    drive_idle(); #1;
    check("bubble mispredict", 32'(bp.mispredict), 32'h0);
    check("bubble bcnt",       bp.branch_cnt,      32'd12);

    random_phase(1500);

    // Reset during a mispredict pulse, with a pending table write held on EX
    drive_ex(1'b1, OP_ADD, 32'h40, 1'b0, 32'h0, 1'b1, 32'h0); step();
    check("pre-rst mispredict", 32'(bp.mispredict), 32'h1);
    drive_ex(1'b1, OP_BR, 32'h80, 1'b1, 32'h600, 1'b0, 32'h0);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst mid mispredict", 32'(bp.mispredict),  32'h0);
    check("rst mid redirect",   bp.redirect_pc,      32'h0);
    check("rst mid bcnt",       bp.branch_cnt,       32'h0);
    check("rst mid mcnt",       bp.mispredict_cnt,   32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive_idle(); look(32'h80);
    check("rst no write", 32'(bp.pred_taken_if), 32'h0);

    random_phase(300);
    drive_idle();
    @(posedge clk); model_update(); #2;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor and misprediction resolver for the pipelined RISC-V core. At fetch, it looks up the current PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and returns a predicted direction and target. At execute, it consumes the resolved outcome from the branch comparator, trains the table, and issues a registered redirect/flush when the prediction was wrong. It also keeps running branch and misprediction counts for performance monitoring.

## Interface

Parameters:
- DWIDTH, 32, data/address width.
- ENTRIES, 16, number of BTB entries; must be a power of two, minimum 2.
- IDXW, $clog2(ENTRIES), index width (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pc_if  input  DWIDTH  PC of the instruction being fetched.
- pred_taken_if  output  1  predicted taken for pc_if (combinational from table state).
- pred_target_if  output  DWIDTH  predicted target for pc_if; 0 when pred_taken_if=0.
- valid_ex  input  1  EX stage holds a real, non-bubbled instruction.
- instruction_ex  input  DWIDTH  EX-stage instruction word; opcode = bits [6:0].
- pc_ex  input  DWIDTH  PC of the EX-stage instruction.
- taken_ex  input  1  resolved taken signal from the branch comparator.
- target_ex  input  DWIDTH  resolved target address from the ALU.
- pred_taken_ex  input  1  prediction made at fetch, carried down the pipeline.
- pred_target_ex  input  DWIDTH  predicted target, carried down the pipeline.
- mispredict  output  1  registered one-cycle pulse requesting a flush of IF/ID/EX.
- redirect_pc  output  DWIDTH  registered correct next PC; valid while mispredict=1.
- branch_cnt  output  32  number of resolved control-flow instructions (wraps).
- mispredict_cnt  output  32  number of mispredictions (wraps).

## Operation

- Control-flow instruction (cfi): opcode is 1100011 (branch), 1101111 (JAL) or 1100111 (JALR).
- Index is pc[IDXW+1:2]. Tag is pc[DWIDTH-1:IDXW+2].
- Each entry holds a valid bit, a tag, a DWIDTH-bit target, and a 2-bit counter.
- Lookup:
  - hit = valid && tag match.
  - pred_taken_if = hit && ctr[1].
  - pred_target_if = pred_taken_if ? target : 0.
- Update applies when valid_ex && cfi, to the entry at pc_ex's index:
  - Branch, taken: ctr saturates upward (11 stays 11). Write tag, target = target_ex, valid = 1.
  - Branch, not taken: on a hit, ctr saturates downward (00 stays 00). On a miss, no allocation and the entry is left unchanged.
  - JAL/JALR, taken: write tag, target = target_ex, valid = 1, ctr = 11.
  - A newly allocated entry whose tag differed is written with ctr = 10 for branches and 11 for jumps.
- Misprediction condition (m), evaluated when valid_ex=1:
  - cfi && (taken_ex != pred_taken_ex), or
  - cfi && taken_ex && pred_taken_ex && (target_ex != pred_target_ex), or
  - !cfi && pred_taken_ex.
- Correct PC = (cfi && taken_ex) ? target_ex : pc_ex + 4. The +4 is computed mod 2^DWIDTH.
- When valid_ex=0: no update, no count, and m = 0.
- Counters:
  - branch_cnt increments when valid_ex && cfi.
  - mispredict_cnt increments on m.
  - Both wrap from 0xFFFFFFFF to 0.

## Timing

- Reset (asynchronous, rst_n=0):
  - All valid bits = 0, all counters = 01, all targets and tags = 0.
  - mispredict = 0, redirect_pc = 0, branch_cnt = 0, mispredict_cnt = 0.
  - Reset asserted mid-operation discards any pending redirect and table write immediately.
- Lookup is zero-latency (combinational) from registered table state.
- Table update is written at the rising edge closing the EX cycle.
- A same-cycle lookup of the same index returns the pre-update value. The updated value is visible from the next cycle.
- mispredict and redirect_pc are registered, one cycle after the EX cycle in which m holds:
  - mispredict is high for exactly one cycle per event.
  - Back-to-back events produce back-to-back pulses.
  - redirect_pc holds its last value while mispredict = 0.
- Counters update at the same edge as the table.

## Test plan

- Reset, then pc_if=0x100 → pred_taken_if=0, pred_target_if=0; mispredict=0, redirect_pc=0; both counts 0.
- Training, same branch:
  - BEQ at pc_ex=0x100, taken_ex=1, target_ex=0x80, pred_taken_ex=0 → next cycle mispredict=1, redirect_pc=0x80; then pc_if=0x100 gives pred_taken_if=1, pred_target_if=0x80.
  - The same branch resolved not-taken twice → pred_taken_if=0 after the second update; the second resolution (pred_taken_ex=1) yields redirect_pc=0x104.
- Saturation: 5 consecutive taken resolutions of BNE at 0x200 → ctr=11. One not-taken → prediction still taken (ctr=10).
- JALR at 0x300: target 0x400 allocated; later resolves to 0x500 with pred_target_ex=0x400 → mispredict, redirect_pc=0x500, target updated to 0x500.
- Aliasing and non-cfi:
  - PCs 0x100 and 0x100+4·ENTRIES → tag mismatch, no false hit.
  - ADD with pred_taken_ex=1 at pc_ex=0x40 → mispredict, redirect_pc=0x44, table unchanged, branch_cnt unchanged.
- Wrap and reset:
  - pc_ex=0xFFFFFFFC, not-taken branch mispredicted → redirect_pc=0x0.
  - Assert rst_n=0 during a mispredict cycle → mispredict drops immediately and all state is cleared.
